// File: rtl/alp_pkg.sv
// Package: alp_pkg
// Shared types for the ALP sequential core.
//   op_e    : 3-bit opcode as presented on i_op
//   state_e : controller FSM states
//   cmd_e   : which IDLE command is being executed in StExec
//   FLAG_*  : bit positions inside the {N,Z,C,V} flag vector
package alp_pkg;

    typedef enum logic [2:0] {
        OpAdd    = 3'b000,
        OpSub    = 3'b001,
        OpMul    = 3'b010,
        OpDiv    = 3'b011,
        OpAnd    = 3'b100,
        OpOr     = 3'b101,
        OpXor    = 3'b110,
        OpBitclr = 3'b111
    } op_e;

    typedef enum logic [3:0] {
        StIdle,
        StExec,
        StMInit,
        StMIter,
        StMWb,
        StDAbs,
        StDIter,
        StDFix,
        StDWb
    } state_e;

    typedef enum logic [1:0] {
        CmdStart,
        CmdClr,
        CmdLoad
    } cmd_e;

    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/alp_alu.sv
// Module: alp_alu
// Combinational WIDTH-bit ALU shared by the single-cycle ops, the Booth
// add/subtract step and the divider trial subtract.
// Ports:
//   i_op  opcode (only add/sub/and/or/xor/bitclr are meaningful; others add)
//   i_a   left operand
//   i_b   right operand
//   o_y   result, modulo 2^WIDTH
//   o_c   carry-out for add, not-borrow for sub, 0 otherwise
//   o_v   signed overflow for add/sub, 0 otherwise
module alp_alu
    import alp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y,
    output logic             o_c,
    output logic             o_v
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;

    always_comb begin
        // Subtract as a + ~b + 1 so the carry-out is directly the not-borrow.
        w_sub   = (i_op == OpSub);
        w_b_eff = w_sub ? ~i_b : i_b;
        w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
        o_y     = w_sum[WIDTH-1:0];
        o_c     = 1'b0;
        o_v     = 1'b0;
        case (i_op)
            OpAdd, OpSub: begin
                o_c = w_sum[WIDTH];
                o_v = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OpAnd:    o_y = i_a & i_b;
            OpOr:     o_y = i_a | i_b;
            OpXor:    o_y = i_a ^ i_b;
            OpBitclr: o_y = i_a & ~i_b;
            default:  ;
        endcase
    end

endmodule

// File: rtl/alp_seq_core.sv
// Module: alp_seq_core
// Sequential ALP controller: owns R0/R1, runs single-cycle ALU ops, a signed
// Booth multiply and (optionally) a signed restoring divide behind a
// start/busy/done handshake, and keeps NZCV flags plus a sticky error bit.
// Build option: define ALP_DIV_EN to include the divider; without it op 011
// only raises o_err.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_op       run opcode i_op (IDLE only, highest priority)
//   i_clr               clear R0/R1/flags/err (IDLE only)
//   i_load, i_data_in   R1<=R0, R0<=i_data_in (IDLE only, lowest priority)
//   o_r0, o_r1          architectural registers
//   o_flags             {N,Z,C,V}
//   o_busy              high whenever the FSM is not idle
//   o_done              one-cycle completion pulse
//   o_err               sticky divide-by-zero / illegal-op error
module alp_seq_core
    import alp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data_in,
    output logic [WIDTH-1:0] o_r0,
    output logic [WIDTH-1:0] o_r1,
    output logic [3:0]       o_flags,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam int unsigned SC_W = $clog2(WIDTH) + 1;

    state_e           r_state, w_state_next;
    cmd_e             r_cmd;
    op_e              r_op;
    logic [WIDTH-1:0] r_r0, r_r1;
    logic [WIDTH-1:0] r_a, r_q, r_m;   // r_m is also the load holding register and divisor
    logic             r_q1;
    logic [SC_W-1:0]  r_sc;
    logic [3:0]       r_flags;
    logic             r_done, r_err;

    op_e              w_alu_op;
    logic [WIDTH-1:0] w_alu_a, w_alu_b, w_alu_y;
    logic             w_alu_c, w_alu_v;
    logic             w_sc_last;
    logic             w_booth_act;
    logic [WIDTH-1:0] w_booth_a;
    logic             w_booth_qin;

`ifdef ALP_DIV_EN
    logic             r_qs, r_as;
    logic [WIDTH-1:0] w_div_a;
`endif

    alp_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_op (w_alu_op),
        .i_a  (w_alu_a),
        .i_b  (w_alu_b),
        .o_y  (w_alu_y),
        .o_c  (w_alu_c),
        .o_v  (w_alu_v)
    );

    always_comb begin
        w_alu_op    = r_op;
        w_alu_a     = r_r0;
        w_alu_b     = r_r1;
        w_sc_last   = (r_sc == SC_W'(1));
        w_booth_act = r_q[0] ^ r_q1;
        // A true Booth sum can exceed WIDTH signed bits (M = -2^(W-1)); the
        // real sign is msb ^ overflow, which is what the shift must replicate.
        w_booth_a   = w_booth_act ? {w_alu_y[WIDTH-1] ^ w_alu_v, w_alu_y[WIDTH-1:1]}
                                  : {r_a[WIDTH-1], r_a[WIDTH-1:1]};
        w_booth_qin = w_booth_act ? w_alu_y[0] : r_a[0];
        if (r_state == StMIter) begin
            w_alu_op = r_q[0] ? OpSub : OpAdd;
            w_alu_a  = r_a;
            w_alu_b  = r_m;
        end
`ifdef ALP_DIV_EN
        // Shifted A is below 2^WIDTH, so the WIDTH-bit not-borrow acts as the
        // sign of the WIDTH+1-bit trial difference.
        w_div_a = {r_a[WIDTH-2:0], r_q[WIDTH-1]};
        if (r_state == StDIter) begin
            w_alu_op = OpSub;
            w_alu_a  = w_div_a;
            w_alu_b  = r_m;
        end
`endif
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (i_op == OpMul) begin
                        w_state_next = StMInit;
`ifdef ALP_DIV_EN
                    end else if (i_op == OpDiv) begin
                        w_state_next = StDAbs;
`endif
                    end else begin
                        w_state_next = StExec;
                    end
                end else if (i_clr || i_load) begin
                    w_state_next = StExec;
                end
            end
            StExec:  w_state_next = StIdle;
            StMInit: w_state_next = StMIter;
            StMIter: if (w_sc_last) w_state_next = StMWb;
            StMWb:   w_state_next = StIdle;
`ifdef ALP_DIV_EN
            StDAbs:  w_state_next = (r_r0 == '0) ? StIdle : StDIter;
            StDIter: if (w_sc_last) w_state_next = StDFix;
            StDFix:  w_state_next = StDWb;
            StDWb:   w_state_next = StIdle;
`endif
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cmd   <= CmdStart;
            r_op    <= OpAdd;
            r_r0    <= '0;
            r_r1    <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_q1    <= 1'b0;
            r_sc    <= '0;
            r_flags <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef ALP_DIV_EN
            r_qs    <= 1'b0;
            r_as    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_cmd <= CmdStart;
                        r_op  <= op_e'(i_op);
                        r_err <= 1'b0;
                    end else if (i_clr) begin
                        r_cmd <= CmdClr;
                    end else if (i_load) begin
                        r_cmd <= CmdLoad;
                        r_m   <= i_data_in;
                    end
                end
                StExec: begin
                    r_done <= 1'b1;
                    case (r_cmd)
                        CmdClr: begin
                            r_r0    <= '0;
                            r_r1    <= '0;
                            r_flags <= '0;
                            r_err   <= 1'b0;
                        end
                        CmdLoad: begin
                            r_r1 <= r_r0;
                            r_r0 <= r_m;
                        end
                        default: begin
                            // Only an unsupported op (divide when not built) lands here.
                            if (r_op == OpDiv || r_op == OpMul) begin
                                r_err <= 1'b1;
                            end else begin
                                r_r0            <= w_alu_y;
                                r_r1            <= '0;
                                r_flags[FLAG_N] <= w_alu_y[WIDTH-1];
                                r_flags[FLAG_Z] <= (w_alu_y == '0);
                                r_flags[FLAG_C] <= w_alu_c;
                                r_flags[FLAG_V] <= w_alu_v;
                            end
                        end
                    endcase
                end
                StMInit: begin
                    r_a  <= '0;
                    r_q  <= r_r1;
                    r_q1 <= 1'b0;
                    r_m  <= r_r0;
                    r_sc <= SC_W'(WIDTH);
                end
                StMIter: begin
                    r_a  <= w_booth_a;
                    r_q  <= {w_booth_qin, r_q[WIDTH-1:1]};
                    r_q1 <= r_q[0];
                    r_sc <= r_sc - 1'b1;
                end
                StMWb: begin
                    r_done  <= 1'b1;
                    r_r0    <= r_a;
                    r_r1    <= r_q;
                    r_flags <= {r_a[WIDTH-1], (r_a == '0) && (r_q == '0), 2'b00};
                end
`ifdef ALP_DIV_EN
                StDAbs: begin
                    if (r_r0 == '0) begin
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                    end else begin
                        r_qs <= r_r1[WIDTH-1] ^ r_r0[WIDTH-1];
                        r_as <= r_r1[WIDTH-1];
                        r_q  <= r_r1[WIDTH-1] ? -r_r1 : r_r1;
                        r_m  <= r_r0[WIDTH-1] ? -r_r0 : r_r0;
                        r_a  <= '0;
                        r_sc <= SC_W'(WIDTH);
                    end
                end
                StDIter: begin
                    r_a  <= w_alu_c ? w_alu_y : w_div_a;
                    r_q  <= {r_q[WIDTH-2:0], w_alu_c};
                    r_sc <= r_sc - 1'b1;
                end
                StDFix: begin
                    if (r_qs) r_q <= -r_q;
                    if (r_as) r_a <= -r_a;
                end
                StDWb: begin
                    r_done  <= 1'b1;
                    r_r1    <= r_q;
                    r_r0    <= r_a;
                    // A non-negative quotient with msb set only arises from -2^(W-1)/-1.
                    r_flags <= {r_a[WIDTH-1], (r_a == '0), 1'b0, ~r_qs & r_q[WIDTH-1]};
                end
`endif
                default: ;
            endcase
        end
    end

    assign o_r0    = r_r0;
    assign o_r1    = r_r1;
    assign o_flags = r_flags;
    assign o_busy  = (r_state != StIdle);
    assign o_done  = r_done;
    assign o_err   = r_err;

endmodule

// File: tb/tb_alp_seq_core.sv
// Testbench for alp_seq_core (WIDTH=8): directed vector table, hand-written
// multi-cycle sequences and randomized ops against an arithmetic reference.
// Latency below is the number of clock edges after the edge that samples a
// command until o_done is visible.
module tb_alp_seq_core;

    localparam int LAT_MUL = 10;
    localparam int LAT_DIV = 11;

    logic       clk = 1'b0;
    logic       rst, start, clr, load;
    logic [2:0] op;
    logic [7:0] din;
    logic [7:0] r0, r1;
    logic [3:0] flags;
    logic       busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [3:0] ef;
        logic       ee;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    alp_seq_core #(
        .WIDTH (8)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_op      (op),
        .i_clr     (clr),
        .i_load    (load),
        .i_data_in (din),
        .o_r0      (r0),
        .o_r1      (r1),
        .o_flags   (flags),
        .o_busy    (busy),
        .o_done    (done),
        .o_err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one command for one sampling edge, then wait (bounded) for done.
    task automatic issue(input logic s, input logic c, input logic l, input logic [2:0] o,
                         input logic [7:0] d, output int lat);
        @(negedge clk);
        start = s; clr = c; load = l; op = o; din = d;
        @(posedge clk);
        #1;
        start = 1'b0; clr = 1'b0; load = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done, expected done within 50 edges");
        end
    endtask

    task automatic add_vec(input logic [2:0] o, input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [3:0] ef,
                           input logic ee, input int lat);
        vec_t v;
        v = '{o, a0, a1, e0, e1, ef, ee, lat};
        vecs.push_back(v);
    endtask

    // Reference: results from plain signed/unsigned integer arithmetic.
    task automatic ref_op(input logic [2:0] o, input logic [7:0] a0, input logic [7:0] a1,
                          input logic [3:0] fin, output logic [7:0] n0, output logic [7:0] n1,
                          output logic [3:0] fo, output logic e, output int lat);
        int sa, sb, s, p, q, rm;
        logic [31:0] t;
        logic c, v;
        sa = $signed(a0);
        sb = $signed(a1);
        n0 = a0; n1 = a1; fo = fin; e = 1'b0; lat = 1;
        case (o)
            3'b000, 3'b001: begin
                if (o == 3'b000) begin
                    t = {24'b0, a0} + {24'b0, a1};
                    c = t[8];
                    s = sa + sb;
                end else begin
                    t = {24'b0, a0} - {24'b0, a1};
                    c = (a0 >= a1);
                    s = sa - sb;
                end
                v  = (s > 127) || (s < -128);
                n0 = t[7:0];
                n1 = 8'h00;
                fo = {n0[7], n0 == 8'h00, c, v};
            end
            3'b100, 3'b101, 3'b110, 3'b111: begin
                case (o)
                    3'b100:  n0 = a0 & a1;
                    3'b101:  n0 = a0 | a1;
                    3'b110:  n0 = a0 ^ a1;
                    default: n0 = a0 & ~a1;
                endcase
                n1 = 8'h00;
                fo = {n0[7], n0 == 8'h00, 2'b00};
            end
            3'b010: begin
                p   = sa * sb;
                t   = p;
                n0  = t[15:8];
                n1  = t[7:0];
                fo  = {p < 0, p == 0, 2'b00};
                lat = LAT_MUL;
            end
            default: begin
`ifdef ALP_DIV_EN
                if (a0 == 8'h00) begin
                    e = 1'b1;
                end else begin
                    q   = sb / sa;
                    rm  = sb % sa;
                    t   = q;
                    n1  = t[7:0];
                    t   = rm;
                    n0  = t[7:0];
                    fo  = {n0[7], n0 == 8'h00, 1'b0, q == 128};
                    lat = LAT_DIV;
                end
`else
                e = 1'b1;
`endif
            end
        endcase
    endtask

    initial begin
        int lat, busy_cnt;
        logic [7:0] m0, m1, n0, n1;
        logic [3:0] mf, nf;
        logic ne;
        logic [2:0] rop;

        rst = 1'b1; start = 1'b0; clr = 1'b0; load = 1'b0; op = 3'b000; din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_outputs", {r0, r1, flags, busy, done, err}, 27'h0);

        // op, R0, R1 -> R0, R1, {N,Z,C,V}, err, latency
        add_vec(3'b000, 8'd100, 8'd100, 8'hC8, 8'h00, 4'b1001, 1'b0, 1);
        add_vec(3'b001, 8'h05,  8'h05,  8'h00, 8'h00, 4'b0110, 1'b0, 1);
        add_vec(3'b001, 8'h03,  8'h05,  8'hFE, 8'h00, 4'b1000, 1'b0, 1);
        add_vec(3'b001, 8'h80,  8'h01,  8'h7F, 8'h00, 4'b0011, 1'b0, 1);
        add_vec(3'b000, 8'hFF,  8'h01,  8'h00, 8'h00, 4'b0110, 1'b0, 1);
        add_vec(3'b100, 8'hF0,  8'h3C,  8'h30, 8'h00, 4'b0000, 1'b0, 1);
        add_vec(3'b101, 8'hF0,  8'h0F,  8'hFF, 8'h00, 4'b1000, 1'b0, 1);
        add_vec(3'b110, 8'hAA,  8'hAA,  8'h00, 8'h00, 4'b0100, 1'b0, 1);
        add_vec(3'b111, 8'hFF,  8'h0F,  8'hF0, 8'h00, 4'b1000, 1'b0, 1);
        add_vec(3'b010, 8'hFD,  8'h05,  8'hFF, 8'hF1, 4'b1000, 1'b0, LAT_MUL);
        add_vec(3'b010, 8'h00,  8'h07,  8'h00, 8'h00, 4'b0100, 1'b0, LAT_MUL);
        add_vec(3'b010, 8'h80,  8'h80,  8'h40, 8'h00, 4'b0000, 1'b0, LAT_MUL);
        add_vec(3'b011, 8'h00,  8'h07,  8'h00, 8'h07, 4'b0000, 1'b1, 1);
`ifdef ALP_DIV_EN
        add_vec(3'b011, 8'h02,  8'hF9,  8'hFF, 8'hFD, 4'b1000, 1'b0, LAT_DIV);
        add_vec(3'b011, 8'hFF,  8'h80,  8'h00, 8'h80, 4'b0101, 1'b0, LAT_DIV);
`else
        add_vec(3'b011, 8'h02,  8'hF9,  8'h02, 8'hF9, 4'b0000, 1'b1, 1);
`endif

        foreach (vecs[i]) begin
            issue(1'b0, 1'b1, 1'b0, 3'b000, 8'h00, lat);
            issue(1'b0, 1'b0, 1'b1, 3'b000, vecs[i].r1, lat);
            issue(1'b0, 1'b0, 1'b1, 3'b000, vecs[i].r0, lat);
            issue(1'b1, 1'b0, 1'b0, vecs[i].op, 8'h00, lat);
            check($sformatf("vec%0d_r0", i), r0, vecs[i].e0);
            check($sformatf("vec%0d_r1", i), r1, vecs[i].e1);
            check($sformatf("vec%0d_flags", i), flags, vecs[i].ef);
            check($sformatf("vec%0d_err", i), err, vecs[i].ee);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Error clears on the next start; R0=0,R1=7 left by the div-by-zero vector.
        issue(1'b0, 1'b1, 1'b0, 3'b000, 8'h00, lat);
        issue(1'b0, 1'b0, 1'b1, 3'b000, 8'h07, lat);
        issue(1'b0, 1'b0, 1'b1, 3'b000, 8'h00, lat);
        issue(1'b1, 1'b0, 1'b0, 3'b011, 8'h00, lat);
        check("divzero_err", err, 1'b1);
        issue(1'b1, 1'b0, 1'b0, 3'b000, 8'h00, lat);
        check("err_cleared_by_start", err, 1'b0);
        check("add_after_err_r0", r0, 8'h07);

        // Load shifting and clr priority over load.
        issue(1'b0, 1'b0, 1'b1, 3'b000, 8'h12, lat);
        issue(1'b0, 1'b0, 1'b1, 3'b000, 8'h34, lat);
        check("load_pair", {r1, r0}, 16'h1234);
        issue(1'b0, 1'b1, 1'b1, 3'b000, 8'h55, lat);
        check("clr_beats_load", {r1, r0}, 16'h0000);
        check("clr_latency", lat, 1);

        // Multiply busy window, done pulse width, and start ignored while busy.
        issue(1'b0, 1'b0, 1'b1, 3'b000, 8'h05, lat);
        issue(1'b0, 1'b0, 1'b1, 3'b000, 8'hFD, lat);
        @(negedge clk);
        start = 1'b1; op = 3'b010;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (done !== 1'b1 && lat < 50) begin
            if (busy === 1'b1) busy_cnt++;
            if (lat == 3) begin
                start = 1'b1; op = 3'b000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check("mul_busy_cycles", busy_cnt, LAT_MUL);
        check("mul_done_edge", lat, LAT_MUL);
        check("mul_result", {r0, r1}, 16'hFFF1);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 1'b0);
        check("start_not_queued", busy, 1'b0);
        check("result_kept", {r0, r1}, 16'hFFF1);

        // Synchronous reset in the 4th busy cycle of a multiply.
        @(negedge clk);
        start = 1'b1; op = 3'b010;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_mid_mul", {r0, r1, flags, busy, done, err}, 27'h0);

        // Randomized ops against the reference.
        issue(1'b0, 1'b1, 1'b0, 3'b000, 8'h00, lat);
        m0 = 8'h00; m1 = 8'h00; mf = 4'h0;
        for (int k = 0; k < 150; k++) begin
            rop = 3'($urandom_range(0, 7));
            m1  = 8'($urandom);
            m0  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            issue(1'b0, 1'b0, 1'b1, 3'b000, m1, lat);
            issue(1'b0, 1'b0, 1'b1, 3'b000, m0, lat);
            issue(1'b1, 1'b0, 1'b0, rop, 8'h00, lat);
            ref_op(rop, m0, m1, mf, n0, n1, nf, ne, busy_cnt);
            check($sformatf("rnd%0d_op%0d_r0r1", k, rop), {r0, r1}, {n0, n1});
            check($sformatf("rnd%0d_op%0d_flags_err", k, rop), {flags, err}, {nf, ne});
            check($sformatf("rnd%0d_op%0d_latency", k, rop), lat, busy_cnt);
            mf = nf;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
